// File: rtl/tx_uart.sv
// UART serial transmitter: start bit, LSB-first data, optional parity, stop period.
// Bit timing is driven by the shared 16x baud tick used as a clock enable; dbg_state exposes the FSM (IDLE = 0).
module tx_uart #(
    parameter int NB_DATA         = 8,
    parameter int NB_COUNT        = 5,
    parameter int NB_DATA_COUNT   = 4,
    parameter int TICKS_PER_BIT   = 16,
    parameter int N_TICKS_TO_STOP = 16,
    parameter int PARITY_EN       = 0,
    parameter int PARITY_ODD      = 0
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic               i_s_tick,
    input  logic               i_tx_start,
    input  logic [NB_DATA-1:0] i_data,
    output logic               o_tx,
    output logic               o_tx_busy,
    output logic               o_tx_done_tick,
    output logic [2:0]         dbg_state
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    localparam logic [NB_COUNT-1:0]      TICK_LAST = NB_COUNT'(TICKS_PER_BIT - 1);
    localparam logic [NB_COUNT-1:0]      STOP_LAST = NB_COUNT'(N_TICKS_TO_STOP - 1);
    localparam logic [NB_DATA_COUNT-1:0] BIT_LAST  = NB_DATA_COUNT'(NB_DATA - 1);
    localparam logic [NB_COUNT-1:0]      TICK_ONE  = NB_COUNT'(1);
    localparam logic [NB_DATA_COUNT-1:0] BIT_ONE   = NB_DATA_COUNT'(1);

    state_t                   state_reg, state_next;
    logic [NB_COUNT-1:0]      tick_reg, tick_next;
    logic [NB_DATA_COUNT-1:0] bit_reg, bit_next;
    logic [NB_DATA-1:0]       shift_reg, shift_next;
    logic                     par_reg, par_next;
    logic                     tx_reg, tx_next;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_reg <= IDLE;
            tick_reg  <= '0;
            bit_reg   <= '0;
            shift_reg <= '0;
            par_reg   <= 1'b0;
            tx_reg    <= 1'b1;
        end else begin
            state_reg <= state_next;
            tick_reg  <= tick_next;
            bit_reg   <= bit_next;
            shift_reg <= shift_next;
            par_reg   <= par_next;
            tx_reg    <= tx_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        tick_next      = tick_reg;
        bit_next       = bit_reg;
        shift_next     = shift_reg;
        par_next       = par_reg;
        o_tx_done_tick = 1'b0;
        case (state_reg)
            IDLE: begin
                if (i_tx_start) begin
                    // Parity is fixed from the accepted byte, since the shift register is consumed.
                    shift_next = i_data;
                    par_next   = (^i_data) ^ (PARITY_ODD != 0);
                    tick_next  = '0;
                    bit_next   = '0;
                    state_next = START;
                end
            end
            START: begin
                if (i_s_tick) begin
                    if (tick_reg == TICK_LAST) begin
                        tick_next  = '0;
                        state_next = DATA;
                    end else begin
                        tick_next = tick_reg + TICK_ONE;
                    end
                end
            end
            DATA: begin
                if (i_s_tick) begin
                    if (tick_reg == TICK_LAST) begin
                        tick_next  = '0;
                        shift_next = shift_reg >> 1;
                        if (bit_reg == BIT_LAST) begin
                            bit_next   = '0;
                            state_next = (PARITY_EN != 0) ? PARITY : STOP;
                        end else begin
                            bit_next = bit_reg + BIT_ONE;
                        end
                    end else begin
                        tick_next = tick_reg + TICK_ONE;
                    end
                end
            end
            PARITY: begin
                if (i_s_tick) begin
                    if (tick_reg == TICK_LAST) begin
                        tick_next  = '0;
                        state_next = STOP;
                    end else begin
                        tick_next = tick_reg + TICK_ONE;
                    end
                end
            end
            STOP: begin
                if (i_s_tick) begin
                    if (tick_reg == STOP_LAST) begin
                        tick_next      = '0;
                        o_tx_done_tick = 1'b1;
                        state_next     = IDLE;
                    end else begin
                        tick_next = tick_reg + TICK_ONE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Line level is registered from the next state so o_tx changes on the same edge as the state.
    always_comb begin
        tx_next = 1'b1;
        case (state_next)
            START:   tx_next = 1'b0;
            DATA:    tx_next = shift_next[0];
            PARITY:  tx_next = par_next;
            default: tx_next = 1'b1;
        endcase
    end

    assign o_tx      = tx_reg;
    assign o_tx_busy = (state_reg != IDLE);
    assign dbg_state = state_reg;

endmodule

// File: doc/tx_uart.md
Name: tx_uart

Overview:
- UART serial transmitter; the transmit-side counterpart of the 16x-oversampling UART receiver in the TP2-UART design.
- Accepts a parallel byte on a single-cycle start strobe and serialises it on o_tx: start bit, data LSB-first, optional parity, stop bit(s).
- Bit timing comes from the shared baud-rate generator tick (i_s_tick), used as a clock enable.
- Sits between the TX FIFO/interface FSM and the board TX pin.

Parameters:
NB_DATA, 8, data bits per frame
NB_COUNT, 5, tick counter width (must hold max(TICKS_PER_BIT, N_TICKS_TO_STOP)-1)
NB_DATA_COUNT, 4, data bit counter width
TICKS_PER_BIT, 16, i_s_tick pulses per start/data/parity bit
N_TICKS_TO_STOP, 16, i_s_tick pulses for the whole stop period (16 = 1 stop bit, 32 = 2)
PARITY_EN, 0, 1 inserts a parity bit after the data bits
PARITY_ODD, 0, 0 = even parity, 1 = odd parity (ignored when PARITY_EN = 0)

Ports:
i_clock  in  1  system clock; all logic on rising edge
i_reset  in  1  synchronous, active-high reset
i_s_tick  in  1  baud tick, one-cycle pulse at 16x baud rate; clock enable only
i_tx_start  in  1  one-cycle request to send i_data
i_data  in  NB_DATA  byte to send; sampled only when a request is accepted
o_tx  out  1  serial line, idles high
o_tx_busy  out  1  high from the cycle after acceptance until the frame ends
o_tx_done_tick  out  1  one-clock pulse on the last stop tick

Behaviour:
- One clock domain, one clock: i_clock. i_reset is synchronous and active-high. i_s_tick is never used as a clock.
- Reset values: state IDLE, o_tx = 1, o_tx_busy = 0, o_tx_done_tick = 0. Tick counter, bit counter and shift register are cleared.
- Reset mid-frame aborts the frame. o_tx returns high on the clock edge where reset is sampled, and no done pulse is produced.
- States: IDLE, START, DATA, PARITY, STOP. o_tx is registered, and o_tx_busy = (state != IDLE).
- IDLE, o_tx = 1:
  - i_tx_start = 1 latches i_data into the shift register, clears both counters and moves to START on the next edge.
  - Acceptance does not wait for a tick.
- START, o_tx = 0:
  - Advances on i_s_tick only.
  - When the tick counter is TICKS_PER_BIT-1 on a tick: clear the counter and go to DATA.
- DATA, o_tx = shift register bit 0:
  - On a tick with the counter at TICKS_PER_BIT-1: shift right, clear the counter, increment the bit counter.
  - After bit NB_DATA-1: go to PARITY if PARITY_EN, else STOP.
- PARITY, o_tx = XOR of the latched byte XOR PARITY_ODD:
  - Parity is computed from the byte captured at acceptance, not from the shifted register.
  - Lasts TICKS_PER_BIT ticks, then goes to STOP.
- STOP, o_tx = 1:
  - Lasts N_TICKS_TO_STOP ticks.
  - On the tick where the counter is N_TICKS_TO_STOP-1: o_tx_done_tick = 1 for exactly that clock, and the state returns to IDLE.
- Frame length is TICKS_PER_BIT*(1+NB_DATA+PARITY_EN)+N_TICKS_TO_STOP ticks; 160 ticks with defaults.
- Counters only change on clocks where i_s_tick = 1. Clocks without a tick hold all state.
- i_tx_start while busy (including the done cycle) is ignored, with no queuing. i_data changes while busy have no effect.
- Back-to-back frames: a start accepted on the first IDLE clock after done is legal. The line may be high for as little as one clock beyond the stop period.
- i_s_tick high on every clock is legal: one bit then lasts TICKS_PER_BIT clocks.
- Counters use plain binary increment with no wrap. Each counter is cleared on its terminal value.

Test Plan:
- Reset, then hold idle for 100 clocks -> o_tx = 1, o_tx_busy = 0, o_tx_done_tick = 0 throughout.
- Tick every 4 clocks, start with i_data = 8'hA5 -> o_tx shows 0, 1,0,1,0,0,1,0,1, then 1; each bit lasts 64 clocks; one done pulse at tick 160; a bench-side rx_uart recovers 8'hA5.
- Two back-to-back starts (8'h00, then 8'hFF on the first IDLE clock after done) -> both frames correct, two done pulses, no glitch between the frames.
- Start pulse with i_data = 8'h3C at mid-frame of an 8'h81 transmission -> ignored; only 8'h81 is sent and one done pulse occurs.
- PARITY_EN = 1, i_data = 8'h07: PARITY_ODD = 0 -> parity bit 1; PARITY_ODD = 1 -> parity bit 0; frame is 176 ticks.
- Reset asserted during data bit 4 -> o_tx = 1 and busy = 0 on the next clock, no done pulse; a following 8'h5A frame transmits correctly.
